// File: rtl/lif_pkg.sv
// Shared types and constants for the time-multiplexed LIF neuron scheduler.
// Imported by the update datapath and the scheduler top level.
package lif_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } lif_state_e;

    localparam int DEF_THRESHOLD = 230;
    localparam int DEF_REFRAC    = 2;

    localparam int BETA_HI_SH = 1;
    localparam int BETA_LO_SH = 3;

    // Width of a refractory counter able to hold REFRAC (at least 1 bit).
    function automatic int refr_width(input int refrac);
        return (refrac > 0) ? $clog2(refrac + 1) : 1;
    endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational single-neuron LIF update: leak, integrate, saturate,
// threshold test on the old state and refractory hold.
module lif_update
    import lif_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int RW        = 2,
    parameter int THRESHOLD = DEF_THRESHOLD,
    parameter int REFRAC    = DEF_REFRAC
) (
    input  logic [DATA_W-1:0] s,
    input  logic [RW-1:0]     r,
    input  logic [DATA_W-1:0] c,
    input  logic              beta,
    output logic [DATA_W-1:0] s_next,
    output logic [RW-1:0]     r_next,
    output logic              spike
);

    logic [DATA_W-1:0] leak;
    logic [DATA_W:0]   sum;
    logic              over;

    // Refractory hold wins, then spike on the old state, else leaky integrate.
    always_comb begin
        leak   = beta ? (s >> BETA_HI_SH) : (s >> BETA_LO_SH);
        sum    = {1'b0, c} + {1'b0, leak};
        over   = (s >= DATA_W'(THRESHOLD));
        s_next = '0;
        r_next = '0;
        spike  = 1'b0;
        if (r != '0) begin
            r_next = r - RW'(1);
        end else if (over) begin
            spike  = 1'b1;
            r_next = RW'(REFRAC);
        end else begin
            s_next = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/lif_scheduler.sv
// Sweeps all neurons through one shared LIF update per tick, fetching one
// current per neuron and emitting the index of each neuron that spikes.
module lif_scheduler
    import lif_pkg::*;
#(
    parameter int NUM_NEURONS = 8,
    parameter int IDX_W       = 3,
    parameter int DATA_W      = 8,
    parameter int THRESHOLD   = DEF_THRESHOLD,
    parameter int REFRAC      = DEF_REFRAC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic [NUM_NEURONS-1:0] beta_mask,
    input  logic                   cur_valid,
    output logic                   cur_ready,
    output logic [IDX_W-1:0]       cur_idx,
    input  logic [DATA_W-1:0]      cur_data,
    output logic                   spk_valid,
    input  logic                   spk_ready,
    output logic [IDX_W-1:0]       spk_idx,
    output logic                   busy,
    output logic                   step_done,
    output logic                   overrun,
    input  logic [IDX_W-1:0]       dbg_idx,
    output logic [DATA_W-1:0]      dbg_state
);

    localparam int RW = refr_width(REFRAC);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

    lif_state_e        fsm_q, fsm_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              overrun_q, overrun_d;

    logic [DATA_W-1:0] state_q [NUM_NEURONS];
    logic [DATA_W-1:0] state_d [NUM_NEURONS];
    logic [RW-1:0]     refr_q  [NUM_NEURONS];
    logic [RW-1:0]     refr_d  [NUM_NEURONS];

    logic [DATA_W-1:0] upd_s;
    logic [RW-1:0]     upd_r;
    logic              upd_spike;
    logic              take;

    assign take = (fsm_q == S_FETCH) && cur_valid;

    lif_update #(
        .DATA_W    (DATA_W),
        .RW        (RW),
        .THRESHOLD (THRESHOLD),
        .REFRAC    (REFRAC)
    ) u_update (
        .s      (state_q[idx_q]),
        .r      (refr_q[idx_q]),
        .c      (cur_data),
        .beta   (beta_mask[idx_q]),
        .s_next (upd_s),
        .r_next (upd_r),
        .spike  (upd_spike)
    );

    // Sweep sequencing and sticky overrun on ticks that arrive while busy.
    always_comb begin
        fsm_d     = fsm_q;
        idx_d     = idx_q;
        overrun_d = overrun_q | (tick & (fsm_q != S_IDLE));
        unique case (fsm_q)
            S_IDLE: begin
                if (tick) begin
                    fsm_d = S_FETCH;
                    idx_d = '0;
                end
            end
            S_FETCH: begin
                if (cur_valid) begin
                    if (upd_spike) begin
                        fsm_d = S_EMIT;
                    end else if (idx_q == LAST) begin
                        fsm_d = S_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_EMIT: begin
                if (spk_ready) begin
                    if (idx_q == LAST) begin
                        fsm_d = S_DONE;
                    end else begin
                        fsm_d = S_FETCH;
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                fsm_d = S_IDLE;
                idx_d = '0;
            end
            default: begin
                fsm_d = S_IDLE;
                idx_d = '0;
            end
        endcase
    end

    // Write back the updated neuron when its current is accepted.
    always_comb begin
        state_d = state_q;
        refr_d  = refr_q;
        if (take) begin
            state_d[idx_q] = upd_s;
            refr_d[idx_q]  = upd_r;
        end
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q     <= S_IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    // Per-neuron membrane and refractory registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                state_q[i] <= '0;
                refr_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            refr_q  <= refr_d;
        end
    end

    assign cur_ready = (fsm_q == S_FETCH);
    assign cur_idx   = idx_q;
    assign spk_valid = (fsm_q == S_EMIT);
    assign spk_idx   = idx_q;
    assign busy      = (fsm_q != S_IDLE);
    assign step_done = (fsm_q == S_DONE);
    assign overrun   = overrun_q;
    assign dbg_state = (32'(dbg_idx) < 32'(NUM_NEURONS)) ? state_q[dbg_idx] : '0;

endmodule

// File: tb/tb_lif_scheduler.sv
// Testbench for lif_scheduler: table vectors, directed corner sequences
// and randomized sweeps against a behavioural neuron model.
module tb_lif_scheduler;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [7:0] beta_mask = '0;
    logic       cur_valid = 1'b0;
    logic       cur_ready;
    logic [2:0] cur_idx;
    logic [7:0] cur_data = '0;
    logic       spk_valid;
    logic       spk_ready = 1'b0;
    logic [2:0] spk_idx;
    logic       busy;
    logic       step_done;
    logic       overrun;
    logic [2:0] dbg_idx = '0;
    logic [7:0] dbg_state;

    lif_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .beta_mask (beta_mask),
        .cur_valid (cur_valid),
        .cur_ready (cur_ready),
        .cur_idx   (cur_idx),
        .cur_data  (cur_data),
        .spk_valid (spk_valid),
        .spk_ready (spk_ready),
        .spk_idx   (spk_idx),
        .busy      (busy),
        .step_done (step_done),
        .overrun   (overrun),
        .dbg_idx   (dbg_idx),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Behavioural neuron model: plain integers.
    int ms [N];
    int mr [N];

    // Per-sweep controls and results.
    int   cur_vec [N];
    logic [7:0] mask_v;
    int   stall_v;
    int   hold_idx_v;
    int   hold_cyc_v;
    int   tick_idx_v;
    logic [7:0] spk_seen;

    typedef struct {
        int beta;
        int c1;
        int c2;
        int e1;
        int e2;
        int spk2;
    } vec_t;

    vec_t tbl [N];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic bit model_step(input int n, input int c, input bit beta);
        bit sp;
        int v;
        sp = 1'b0;
        if (mr[n] != 0) begin
            ms[n] = 0;
            mr[n] = mr[n] - 1;
        end else if (ms[n] >= 230) begin
            ms[n] = 0;
            mr[n] = 2;
            sp = 1'b1;
        end else begin
            v = c + (beta ? ms[n] / 2 : ms[n] / 8);
            ms[n] = (v > 255) ? 255 : v;
        end
        return sp;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            ms[i] = 0;
            mr[i] = 0;
        end
    endtask

    task automatic read_dbg(input int n, output int v);
        dbg_idx = 3'(n);
        #1;
        v = int'(dbg_state);
    endtask

    task automatic defaults();
        mask_v = '0;
        stall_v = 0;
        hold_idx_v = -1;
        hold_cyc_v = 0;
        tick_idx_v = -1;
    endtask

    // One full timestep driven from a tick, checked against the model.
    task automatic sweep();
        bit sp;
        int v;
        spk_seen = '0;
        @(negedge clk);
        check("idle_before_tick", busy, 0);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        for (int n = 0; n < N; n++) begin
            check("cur_ready", cur_ready, 1);
            check("cur_idx", cur_idx, n);
            if (!cur_ready) return;
            if (n == hold_idx_v) begin
                for (int h = 0; h < hold_cyc_v; h++) begin
                    @(negedge clk);
                    read_dbg(n, v);
                    check("hold_ready", cur_ready, 1);
                    check("hold_idx", cur_idx, n);
                    check("hold_state", v, ms[n]);
                end
            end
            sp = model_step(n, cur_vec[n], mask_v[n]);
            beta_mask = mask_v;
            cur_data = 8'(cur_vec[n]);
            cur_valid = 1'b1;
            if (n == tick_idx_v) tick = 1'b1;
            @(negedge clk);
            cur_valid = 1'b0;
            tick = 1'b0;
            cur_data = 8'($urandom);
            spk_seen[n] = spk_valid;
            check("spk_valid", spk_valid, int'(sp));
            read_dbg(n, v);
            check("state", v, ms[n]);
            if (spk_valid != sp) return;
            if (sp) begin
                check("spk_idx", spk_idx, n);
                check("emit_no_ready", cur_ready, 0);
                for (int s = 0; s < stall_v; s++) begin
                    @(negedge clk);
                    check("stall_valid", spk_valid, 1);
                    check("stall_idx", spk_idx, n);
                    check("stall_no_ready", cur_ready, 0);
                end
                spk_ready = 1'b1;
                @(negedge clk);
                spk_ready = 1'b0;
            end
        end
        check("step_done", step_done, 1);
        check("busy_done", busy, 1);
        @(negedge clk);
        check("step_done_clr", step_done, 0);
        check("busy_clr", busy, 0);
    endtask

    int v;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0, 10, 10, 10, 11, 0};
        tbl[1] = '{1, 10, 10, 10, 15, 0};
        tbl[2] = '{1, 200, 200, 200, 255, 0};
        tbl[3] = '{0, 200, 200, 200, 225, 0};
        tbl[4] = '{0, 230, 0, 230, 0, 1};
        tbl[5] = '{1, 229, 0, 229, 114, 0};
        tbl[6] = '{1, 228, 255, 228, 255, 0};
        tbl[7] = '{0, 0, 7, 0, 7, 0};

        model_reset();
        defaults();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ready", cur_ready, 0);
        check("rst_spk", spk_valid, 0);
        check("rst_done", step_done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_cur_idx", cur_idx, 0);
        check("rst_spk_idx", spk_idx, 0);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            read_dbg(i, v);
            check("rst_state", v, 0);
        end

        // Table vectors: two ticks, expected states from constants.
        for (int t = 0; t < 2; t++) begin
            defaults();
            for (int i = 0; i < N; i++) begin
                cur_vec[i] = (t == 0) ? tbl[i].c1 : tbl[i].c2;
                mask_v[i] = tbl[i].beta[0];
            end
            sweep();
            for (int i = 0; i < N; i++) begin
                read_dbg(i, v);
                check("tbl_state", v, (t == 0) ? tbl[i].e1 : tbl[i].e2);
                check("tbl_spike", spk_seen[i], (t == 0) ? 0 : tbl[i].spk2);
            end
        end

        // Neuron 2 spikes on the third tick with a 5-cycle stalled consumer,
        // then is held in refractory for two ticks.
        for (int t = 0; t < 4; t++) begin
            defaults();
            mask_v = 8'hFF;
            stall_v = (t == 0) ? 5 : 0;
            for (int i = 0; i < N; i++) cur_vec[i] = 200;
            sweep();
            read_dbg(2, v);
            check("n2_spike", spk_seen[2], (t == 0) ? 1 : 0);
            check("n2_state", v, (t == 3) ? 200 : 0);
        end

        // Tick while busy sets overrun; the sweep completes once.
        check("overrun_pre", overrun, 0);
        defaults();
        tick_idx_v = 4;
        for (int i = 0; i < N; i++) cur_vec[i] = 10;
        sweep();
        check("overrun_set", overrun, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_second_done", step_done, 0);
            check("no_second_busy", busy, 0);
        end

        // Current withheld for 4 cycles at neuron 5.
        defaults();
        hold_idx_v = 5;
        hold_cyc_v = 4;
        mask_v = 8'h5A;
        for (int i = 0; i < N; i++) cur_vec[i] = 30 + i;
        sweep();
        check("overrun_sticky", overrun, 1);

        // Randomized sweeps.
        for (int t = 0; t < 40; t++) begin
            defaults();
            mask_v = 8'($urandom);
            stall_v = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) begin
                hold_idx_v = $urandom_range(0, N - 1);
                hold_cyc_v = $urandom_range(1, 3);
            end
            for (int i = 0; i < N; i++) cur_vec[i] = $urandom_range(0, 255);
            sweep();
        end
        check("overrun_end", overrun, 1);

        // Asynchronous reset mid-sweep at neuron 3.
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        cur_valid = 1'b1;
        cur_data = 8'd50;
        spk_ready = 1'b1;
        for (int w = 0; w < 30; w++) begin
            if (cur_ready && cur_idx == 3) break;
            @(negedge clk);
        end
        cur_valid = 1'b0;
        spk_ready = 1'b0;
        check("mid_idx3", cur_idx, 3);
        check("mid_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("async_busy", busy, 0);
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", cur_ready, 0);
        check("mid_rst_spk", spk_valid, 0);
        check("mid_rst_done", step_done, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_cur_idx", cur_idx, 0);
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) begin
            read_dbg(i, v);
            check("mid_rst_state", v, 0);
        end

        // Scheduler still works after reset.
        defaults();
        for (int i = 0; i < N; i++) cur_vec[i] = 10;
        sweep();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
